ir_strobe_ctrl: RTL and testbench

IR_STROBE_CTRL -- requirements
Module: ir_strobe_ctrl

---
 rtl/ir_strobe_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_ir_strobe_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_strobe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ir_strobe_ctrl
// Description : Burst strobe generator for the IR / barcode LED enables.
//               A rising edge on trig, taken in IDLE with the strobe enabled,
//               starts a burst:
//                 optional delay -> pulses x (on, off) -> one-cycle DONE.
//               The configuration is captured at the start edge. abort
//               returns to IDLE at once. rst clears everything.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               cfg_en              - strobe enable
//               cfg_mode            - 0: irled_en, 1: barcode_en
//               cfg_delay/on/off    - timing in cycles (CNT_W bits)
//               cfg_pulses          - pulses per burst (PCNT_W bits)
//               trig                - frame-sync level; rising edge starts
//               abort               - immediate termination of a burst
//               irled_en/barcode_en - LED enables (registered)
//               busy                - high outside IDLE (registered)
//               done                - one-cycle pulse on normal completion
// Revision    : 1.0 - initial release
// ============================================================================
module ir_strobe_ctrl #(
    parameter int CNT_W  = 16,
    parameter int PCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_en,
    input  logic              cfg_mode,
    input  logic [CNT_W-1:0]  cfg_delay,
    input  logic [CNT_W-1:0]  cfg_on,
    input  logic [CNT_W-1:0]  cfg_off,
    input  logic [PCNT_W-1:0] cfg_pulses,
    input  logic              trig,
    input  logic              abort,
    output logic              irled_en,
    output logic              barcode_en,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_DELAY = 3'd1;
    localparam logic [2:0] c_ST_ON    = 3'd2;
    localparam logic [2:0] c_ST_OFF   = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    localparam logic [CNT_W-1:0]  c_CNT_ONE  = CNT_W'(1);
    localparam logic [PCNT_W-1:0] c_PCNT_ONE = PCNT_W'(1);

    // State and counters
    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [PCNT_W-1:0] r_pcnt;

    // Configuration captured at the start edge
    logic              r_mode;
    logic [CNT_W-1:0]  r_on;
    logic [CNT_W-1:0]  r_off;

    logic              r_trig_d;

    // Output flops
    logic              r_irled;
    logic              r_barcode;
    logic              r_busy;
    logic              r_done;

    // Next-state values
    logic [2:0]        w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [PCNT_W-1:0] w_pcnt_nxt;
    logic              w_mode_nxt;
    logic [CNT_W-1:0]  w_on_nxt;
    logic [CNT_W-1:0]  w_off_nxt;
    logic              w_trig_edge;
    logic              w_start;

    assign w_trig_edge = trig & ~r_trig_d;

    // A burst with zero on-time or zero pulses would be empty, so such a
    // trigger is simply ignored.
    assign w_start = (r_state == c_ST_IDLE) & w_trig_edge & cfg_en &
                     (|cfg_on) & (|cfg_pulses);

    // Each timed state loads its length into r_cnt on entry and leaves when
    // the count is 1, so a length of N occupies exactly N cycles and the
    // counter never has to pass through zero.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pcnt_nxt  = r_pcnt;
        w_mode_nxt  = r_mode;
        w_on_nxt    = r_on;
        w_off_nxt   = r_off;

        case (r_state)
            c_ST_IDLE: begin
                if (w_start) begin
                    w_mode_nxt = cfg_mode;
                    w_on_nxt   = cfg_on;
                    w_off_nxt  = cfg_off;
                    w_pcnt_nxt = cfg_pulses;
                    if (cfg_delay != '0) begin
                        w_state_nxt = c_ST_DELAY;
                        w_cnt_nxt   = cfg_delay;
                    end else begin
                        w_state_nxt = c_ST_ON;
                        w_cnt_nxt   = cfg_on;
                    end
                end
            end

            c_ST_DELAY: begin
                if (r_cnt == c_CNT_ONE) begin
                    w_state_nxt = c_ST_ON;
                    w_cnt_nxt   = r_on;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end

            c_ST_ON: begin
                if (r_cnt == c_CNT_ONE) begin
                    w_pcnt_nxt = r_pcnt - c_PCNT_ONE;
                    if (r_pcnt == c_PCNT_ONE) begin
                        w_state_nxt = c_ST_DONE;
                        w_cnt_nxt   = '0;
                    end else if (r_off != '0) begin
                        w_state_nxt = c_ST_OFF;
                        w_cnt_nxt   = r_off;
                    end else begin
                        // Back-to-back pulses: output stays high.
                        w_state_nxt = c_ST_ON;
                        w_cnt_nxt   = r_on;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end

            c_ST_OFF: begin
                if (r_cnt == c_CNT_ONE) begin
                    w_state_nxt = c_ST_ON;
                    w_cnt_nxt   = r_on;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end

            c_ST_DONE: begin
                w_state_nxt = c_ST_IDLE;
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = '0;
                w_pcnt_nxt  = '0;
            end
        endcase

        // abort wins over everything, including a coincident start in IDLE.
        if (abort) begin
            w_state_nxt = c_ST_IDLE;
            w_cnt_nxt   = '0;
            w_pcnt_nxt  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= '0;
            r_pcnt    <= '0;
            r_mode    <= 1'b0;
            r_on      <= '0;
            r_off     <= '0;
            // Treat trig as already high so a level held through reset
            // release is not mistaken for a new edge.
            r_trig_d  <= 1'b1;
            r_irled   <= 1'b0;
            r_barcode <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pcnt    <= w_pcnt_nxt;
            r_mode    <= w_mode_nxt;
            r_on      <= w_on_nxt;
            r_off     <= w_off_nxt;
            r_trig_d  <= trig;
            // Outputs are registered copies of the next-state decode, so
            // each output comes straight from a flop.
            r_irled   <= (w_state_nxt == c_ST_ON) & ~w_mode_nxt;
            r_barcode <= (w_state_nxt == c_ST_ON) &  w_mode_nxt;
            r_busy    <= (w_state_nxt != c_ST_IDLE);
            r_done    <= (w_state_nxt == c_ST_DONE);
        end
    end

    assign irled_en   = r_irled;
    assign barcode_en = r_barcode;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ir_strobe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ir_strobe_ctrl
// Description : Self-checking bench for ir_strobe_ctrl. The stimulus process
//               queues the expected {irled_en, barcode_en, busy, done} for
//               each clock edge. A monitor pops each entry 1 ns after the
//               edge and compares it with the DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ir_strobe_ctrl;

    localparam int CW = 8;
    localparam int PW = 4;

    // Expected output vectors {irled_en, barcode_en, busy, done}
    localparam logic [3:0] IDL = 4'b0000;
    localparam logic [3:0] BSY = 4'b0010;
    localparam logic [3:0] IR  = 4'b1010;
    localparam logic [3:0] BC  = 4'b0110;
    localparam logic [3:0] DN  = 4'b0011;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_en;
    logic          cfg_mode;
    logic [CW-1:0] cfg_delay;
    logic [CW-1:0] cfg_on;
    logic [CW-1:0] cfg_off;
    logic [PW-1:0] cfg_pulses;
    logic          trig;
    logic          abort;
    logic          irled_en;
    logic          barcode_en;
    logic          busy;
    logic          done;

    typedef struct {
        logic [3:0] e;
        string      tag;
    } exp_t;

    exp_t  exp_q[$];
    string tag = "reset";
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;

    ir_strobe_ctrl #(.CNT_W(CW), .PCNT_W(PW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_en     (cfg_en),
        .cfg_mode   (cfg_mode),
        .cfg_delay  (cfg_delay),
        .cfg_on     (cfg_on),
        .cfg_off    (cfg_off),
        .cfg_pulses (cfg_pulses),
        .trig       (trig),
        .abort      (abort),
        .irled_en   (irled_en),
        .barcode_en (barcode_en),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Monitor: one comparison per queued expectation.
    always @(posedge clk) begin
        exp_t  x;
        logic [3:0] got;
        cyc = cyc + 1;
        #1;
        if (exp_q.size() != 0) begin
            x   = exp_q.pop_front();
            got = {irled_en, barcode_en, busy, done};
            checks = checks + 1;
            if (got !== x.e) begin
                errors = errors + 1;
                $display("FAIL %s cycle %0d: outs {irled,barcode,busy,done} got %b want %b",
                         x.tag, cyc, got, x.e);
            end
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete, got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Queue the expected outputs for the coming edge, then step one cycle.
    task automatic tick(input logic [3:0] e);
        exp_t x;
        x.e   = e;
        x.tag = tag;
        exp_q.push_back(x);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ticks(input int n, input logic [3:0] e);
        for (int i = 0; i < n; i++) tick(e);
    endtask

    task automatic set_cfg(input logic m, input logic [CW-1:0] d,
                           input logic [CW-1:0] o, input logic [CW-1:0] f,
                           input logic [PW-1:0] p);
        cfg_mode   = m;
        cfg_delay  = d;
        cfg_on     = o;
        cfg_off    = f;
        cfg_pulses = p;
    endtask

    initial begin
        rst = 1'b1; abort = 1'b0; trig = 1'b0; cfg_en = 1'b1;
        set_cfg(1'b0, 8'd0, 8'd1, 8'd0, 4'd1);

        tag = "reset";
        ticks(2, IDL);
        rst = 1'b0;
        tick(IDL);

        // Delayed two-pulse burst on irled_en
        tag = "burst_d3o4f2p2";
        set_cfg(1'b0, 8'd3, 8'd4, 8'd2, 4'd2);
        tick(IDL);
        trig = 1'b1;
        ticks(3, BSY);
        ticks(4, IR);
        ticks(2, BSY);
        ticks(4, IR);
        tick(DN);
        tick(IDL);

        // Contiguous pulses on barcode_en; trigger edge while in DONE ignored
        tag = "contig_p3_mode1";
        trig = 1'b0;
        set_cfg(1'b1, 8'd0, 8'd1, 8'd0, 4'd3);
        tick(IDL);
        trig = 1'b1;
        ticks(3, BC);
        trig = 1'b0;
        tick(DN);
        trig = 1'b1;
        tag = "retrig_in_done";
        ticks(2, IDL);

        // Triggers that must not start a burst
        tag = "pulses_zero";
        trig = 1'b0;
        set_cfg(1'b0, 8'd0, 8'd2, 8'd0, 4'd0);
        tick(IDL);
        trig = 1'b1;
        ticks(3, IDL);
        tag = "en_zero";
        trig = 1'b0; cfg_en = 1'b0;
        set_cfg(1'b0, 8'd0, 8'd2, 8'd0, 4'd1);
        tick(IDL);
        trig = 1'b1;
        ticks(3, IDL);
        tag = "on_zero";
        trig = 1'b0; cfg_en = 1'b1;
        set_cfg(1'b1, 8'd0, 8'd0, 8'd0, 4'd1);
        tick(IDL);
        trig = 1'b1;
        ticks(3, IDL);

        // Retrigger and cfg_on change mid-burst have no effect
        tag = "retrig_cfg_change";
        trig = 1'b0;
        set_cfg(1'b0, 8'd0, 8'd3, 8'd1, 4'd2);
        tick(IDL);
        trig = 1'b1;
        tick(IR);
        trig = 1'b0;
        tick(IR);
        trig = 1'b1; cfg_on = 8'd9;
        tick(IR);
        tick(BSY);
        ticks(3, IR);
        tick(DN);
        tick(IDL);

        // Abort during the second pulse, then a fresh burst
        tag = "abort_mid";
        trig = 1'b0;
        set_cfg(1'b1, 8'd1, 8'd2, 8'd1, 4'd3);
        tick(IDL);
        trig = 1'b1;
        tick(BSY);
        ticks(2, BC);
        tick(BSY);
        tick(BC);
        abort = 1'b1;
        tick(IDL);
        abort = 1'b0;
        tick(IDL);
        tag = "after_abort";
        trig = 1'b0;
        tick(IDL);
        trig = 1'b1;
        tick(BSY);
        ticks(2, BC);
        tick(BSY);
        ticks(2, BC);
        tick(BSY);
        ticks(2, BC);
        tick(DN);
        tick(IDL);

        // Abort coincident with a trigger edge in IDLE
        tag = "abort_vs_trig";
        trig = 1'b0;
        tick(IDL);
        trig = 1'b1; abort = 1'b1;
        tick(IDL);
        abort = 1'b0;
        ticks(2, IDL);

        // Reset during OFF with trig held high through release
        tag = "rst_in_off";
        trig = 1'b0;
        set_cfg(1'b0, 8'd0, 8'd1, 8'd3, 4'd2);
        tick(IDL);
        trig = 1'b1;
        tick(IR);
        tick(BSY);
        rst = 1'b1;
        ticks(2, IDL);
        rst = 1'b0;
        ticks(3, IDL);
        tag = "after_rst";
        trig = 1'b0;
        tick(IDL);
        trig = 1'b1;
        tick(IR);
        trig = 1'b0;
        ticks(3, BSY);
        tick(IR);
        tick(DN);
        tick(IDL);

        // Full-scale timing values
        tag = "full_scale_cnt";
        set_cfg(1'b1, 8'd255, 8'd255, 8'd255, 4'd2);
        tick(IDL);
        trig = 1'b1;
        ticks(255, BSY);
        ticks(255, BC);
        ticks(255, BSY);
        ticks(255, BC);
        tick(DN);
        tick(IDL);
        tag = "full_scale_pulses";
        trig = 1'b0;
        set_cfg(1'b0, 8'd0, 8'd1, 8'd0, 4'd15);
        tick(IDL);
        trig = 1'b1;
        ticks(15, IR);
        tick(DN);
        tick(IDL);

        // Let the monitor drain the last entry.
        @(posedge clk);
        #2;
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: pending expectations got %0d want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
